// File: rtl/rca_acc_pkg.sv
// Shared widths and FSM state encodings for the 64-bit sequential accumulator.
package rca_acc_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned ACC_W  = 64;

    typedef logic [1:0] state_t;

    localparam state_t StIdle = 2'd0;
    localparam state_t StLo   = 2'd1;
    localparam state_t StHi   = 2'd2;

endpackage

// File: rtl/rca_word_add.sv
// Combinational WORD_W-bit ripple-carry adder shared by both halves of the accumulate.
module rca_word_add
    import rca_acc_pkg::*;
(
    input  logic [WORD_W-1:0] a,
    input  logic [WORD_W-1:0] b,
    input  logic              c_in,
    output logic [WORD_W-1:0] sum,
    output logic              c_out
);

    always_comb begin
        logic [WORD_W:0] c;
        c    = '0;
        sum  = '0;
        c[0] = c_in;
        for (int i = 0; i < WORD_W; i++) begin
            sum[i]   = a[i] ^ b[i] ^ c[i];
            c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
        c_out = c[WORD_W];
    end

endmodule

// File: rtl/rca_acc64.sv
// 64-bit accumulator built on one 32-bit adder: low word, then high word with carry.
// Define RCA_ACC_SATURATE_EN to clamp acc at all-ones on 64-bit carry-out instead of wrapping.
module rca_acc64
    import rca_acc_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_data,
    output logic [ACC_W-1:0]  acc,
    output logic              acc_valid,
    output logic              overflow
);

    state_t              state_q, state_d;
    logic [WORD_W-1:0]   op_q, op_d;
    logic                carry_q, carry_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic                ovf_q, ovf_d;
    logic                valid_q, valid_d;

    logic [WORD_W-1:0]   add_a, add_b, add_sum;
    logic                add_cin, add_cout;

    // High-word pass adds zero plus the stored low-word carry.
    always_comb begin
        if (state_q == StHi) begin
            add_a   = acc_q[ACC_W-1:WORD_W];
            add_b   = '0;
            add_cin = carry_q;
        end else begin
            add_a   = acc_q[WORD_W-1:0];
            add_b   = op_q;
            add_cin = 1'b0;
        end
    end

    rca_word_add u_word_add (
        .a     (add_a),
        .b     (add_b),
        .c_in  (add_cin),
        .sum   (add_sum),
        .c_out (add_cout)
    );

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        carry_d = carry_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        valid_d = 1'b0;
        if (clear) begin
            state_d = StIdle;
            op_d    = '0;
            carry_d = 1'b0;
            acc_d   = '0;
            ovf_d   = 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        op_d    = in_data;
                        state_d = StLo;
                    end
                end
                StLo: begin
                    acc_d[WORD_W-1:0] = add_sum;
                    carry_d           = add_cout;
                    state_d           = StHi;
                end
                StHi: begin
                    acc_d[ACC_W-1:WORD_W] = add_sum;
                    if (add_cout) begin
                        ovf_d = 1'b1;
`ifdef RCA_ACC_SATURATE_EN
                        acc_d = '1;
`endif
                    end
                    valid_d = 1'b1;
                    state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            op_q    <= '0;
            carry_q <= 1'b0;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            carry_q <= carry_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
            valid_q <= valid_d;
        end
    end

    assign in_ready  = (state_q == StIdle) && !clear;
    assign acc       = acc_q;
    assign acc_valid = valid_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_rca_acc64.sv
// Self-checking bench for rca_acc64: arithmetic reference model plus directed vectors.
module tb_rca_acc64;
    import rca_acc_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        clear;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [63:0] acc;
    logic        acc_valid;
    logic        overflow;

    always #5 clk = ~clk;

    rca_acc64 dut (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .acc       (acc),
        .acc_valid (acc_valid),
        .overflow  (overflow)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Reference model: an accepted operand lands as a full 64-bit sum two edges later.
    logic [63:0] m_acc;
    logic [31:0] m_op;
    logic        m_ovf;
    logic        m_valid;
    int          m_busy;
    logic        preload_req = 1'b0;
    logic [63:0] preload_val = '0;
    logic [64:0] m_sum;

    assign m_sum = {1'b0, m_acc} + {33'b0, m_op};

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_acc <= '0; m_op <= '0; m_ovf <= 1'b0; m_valid <= 1'b0; m_busy <= 0;
        end else if (clear) begin
            m_acc <= '0; m_op <= '0; m_ovf <= 1'b0; m_valid <= 1'b0; m_busy <= 0;
        end else begin
            m_valid <= 1'b0;
            if (m_busy == 0) begin
                if (preload_req) m_acc <= preload_val;
                if (in_valid) begin
                    m_op   <= in_data;
                    m_busy <= 2;
                end
            end else if (m_busy == 2) begin
                m_busy <= 1;
            end else begin
                if (m_sum[64]) begin
                    m_ovf <= 1'b1;
`ifdef RCA_ACC_SATURATE_EN
                    m_acc <= '1;
`else
                    m_acc <= m_sum[63:0];
`endif
                end else begin
                    m_acc <= m_sum[63:0];
                end
                m_valid <= 1'b1;
                m_busy  <= 0;
            end
        end
    end

    logic [63:0] valid_log[$];

    always @(negedge clk) begin
        if (!rst) begin
            chk("in_ready", {63'b0, in_ready}, {63'b0, (m_busy == 0) && !clear});
            chk("acc_valid", {63'b0, acc_valid}, {63'b0, m_valid});
            chk("overflow", {63'b0, overflow}, {63'b0, m_ovf});
            if (m_busy == 0 && !preload_req) chk("acc", acc, m_acc);
            if (acc_valid) valid_log.push_back(acc);
        end
    end

    task automatic send(input logic [31:0] op, input bit keep, output int hs);
        bit done;
        done     = 1'b0;
        in_valid = 1'b1;
        in_data  = op;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (in_ready) done = 1'b1;
            @(posedge clk);
            #1;
        end
        hs = cyc;
        chk("handshake_seen", {63'b0, done}, 64'd1);
        if (!keep) begin
            in_valid = 1'b0;
            in_data  = 32'hDEAD_BEEF;
        end
    endtask

    task automatic wait_valid(output logic [63:0] v, output int lat);
        bit found;
        found = 1'b0;
        v     = '0;
        lat   = 0;
        for (int i = 1; i <= 20 && !found; i++) begin
            @(negedge clk);
            if (acc_valid) begin
                found = 1'b1;
                v     = acc;
                lat   = i;
            end
        end
        chk("acc_valid_seen", {63'b0, found}, 64'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
    endtask

    task automatic preload(input logic [63:0] val);
        preload_val = val;
        preload_req = 1'b1;
        force dut.acc_q = 64'hFFFF_FFFF_FFFF_FFFF;
        @(posedge clk);
        #2;
        release dut.acc_q;
        preload_req = 1'b0;
    endtask

    logic [63:0] v;
    int          lat, h1, h2, h3, base;

    initial begin
        rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_data = '0;
        #12;
        chk("rst_acc", acc, 64'd0);
        chk("rst_acc_valid", {63'b0, acc_valid}, 64'd0);
        chk("rst_overflow", {63'b0, overflow}, 64'd0);
        chk("rst_in_ready", {63'b0, in_ready}, 64'd1);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        send(32'h0000_0005, 1'b0, h1);
        wait_valid(v, lat);
        chk("first_latency", 64'(lat), 64'd3);
        chk("first_sum", v, 64'h5);
        chk("first_ovf", {63'b0, overflow}, 64'd0);

        do_clear();
        send(32'hFFFF_FFFF, 1'b0, h1);
        wait_valid(v, lat);
        chk("lo_full", v, 64'h0000_0000_FFFF_FFFF);
        send(32'h1, 1'b0, h1);
        @(negedge clk);
        @(negedge clk);
        chk("partial_after_lo", acc, 64'h0);
        wait_valid(v, lat);
        chk("carry_into_hi", v, 64'h0000_0001_0000_0000);

        do_clear();
        preload(64'hFFFF_FFFF_FFFF_FFFF);
        send(32'h2, 1'b0, h1);
        wait_valid(v, lat);
`ifdef RCA_ACC_SATURATE_EN
        chk("wrap_sum", v, 64'hFFFF_FFFF_FFFF_FFFF);
`else
        chk("wrap_sum", v, 64'h1);
`endif
        chk("wrap_ovf", {63'b0, overflow}, 64'd1);
        send(32'h3, 1'b0, h1);
        wait_valid(v, lat);
`ifdef RCA_ACC_SATURATE_EN
        chk("after_wrap_sum", v, 64'hFFFF_FFFF_FFFF_FFFF);
`else
        chk("after_wrap_sum", v, 64'h4);
`endif
        chk("sticky_ovf", {63'b0, overflow}, 64'd1);

        do_clear();
        base = valid_log.size();
        send(32'h1, 1'b1, h1);
        send(32'h2, 1'b1, h2);
        send(32'h3, 1'b0, h3);
        wait_valid(v, lat);
        chk("stream_gap_12", 64'(h2 - h1), 64'd3);
        chk("stream_gap_23", 64'(h3 - h2), 64'd3);
        chk("stream_count", 64'(valid_log.size() - base), 64'd3);
        chk("stream_sum0", valid_log[base], 64'd1);
        chk("stream_sum1", valid_log[base + 1], 64'd3);
        chk("stream_sum2", valid_log[base + 2], 64'd6);

        send(32'h9, 1'b0, h1);
        wait_valid(v, lat);
        chk("pre_clear_sum", v, 64'd15);
        send(32'h4, 1'b0, h1);
        @(posedge clk);
        #1;
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        base = valid_log.size();
        @(negedge clk);
        chk("clr_hi_acc", acc, 64'd0);
        chk("clr_hi_valid", {63'b0, acc_valid}, 64'd0);
        chk("clr_hi_ready", {63'b0, in_ready}, 64'd1);
        @(posedge clk);
        #1;

        send(32'h7, 1'b0, h1);
        wait_valid(v, lat);
        chk("pre_idle_clear", v, 64'd7);
        base = valid_log.size();
        clear = 1'b1; in_valid = 1'b1; in_data = 32'h55;
        @(negedge clk);
        chk("clr_idle_ready", {63'b0, in_ready}, 64'd0);
        @(posedge clk);
        #1;
        clear = 1'b0; in_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("clr_idle_acc", acc, 64'd0);
        chk("clr_idle_no_valid", 64'(valid_log.size() - base), 64'd0);
        @(posedge clk);
        #1;

        preload(64'hFFFF_FFFF_FFFF_FFFF);
        send(32'h2, 1'b0, h1);
        wait_valid(v, lat);
        chk("pre_rst_ovf", {63'b0, overflow}, 64'd1);
        send(32'h10, 1'b0, h1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_acc", acc, 64'd0);
        chk("async_rst_valid", {63'b0, acc_valid}, 64'd0);
        chk("async_rst_ovf", {63'b0, overflow}, 64'd0);
        chk("async_rst_ready", {63'b0, in_ready}, 64'd1);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        send(32'h6, 1'b0, h1);
        wait_valid(v, lat);
        chk("post_rst_sum", v, 64'd6);
        chk("post_rst_latency", 64'(lat), 64'd3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
